// File: rtl/serial_sub_pkg.sv
// ----------------------------------------------------------------------------
// serial_sub_pkg
//
// Shared definitions for the digit-serial borrow subtractor:
//   - state_e   : controller states (IDLE, RUN, DONE)
//   - cnt_width : width of the digit step counter, clog2(steps) but never
//                 narrower than one bit so a single-step build still has a
//                 real counter register.
// ----------------------------------------------------------------------------
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // A one-step configuration would otherwise ask for a zero-width counter.
    function automatic int cnt_width(input int steps);
        int w;
        w = $clog2(steps);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/serial_borrow_subtractor_digit_sub.sv
// ----------------------------------------------------------------------------
// full_sub
//
// One-bit full subtractor: d = x - y - bin, with borrow-out.
//   x    : minuend bit
//   y    : subtrahend bit
//   bin  : borrow from the next lower bit
//   d    : difference bit
//   bout : borrow to the next higher bit
// ----------------------------------------------------------------------------
module full_sub (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    // A borrow is needed whenever y + bin exceeds x.
    assign bout = (~x & y) | (~x & bin) | (y & bin);

endmodule

// ----------------------------------------------------------------------------
// digit_sub
//
// Combinational DIGIT-bit ripple-borrow subtractor slice built from full_sub
// cells. Computes d = x - y - bin over DIGIT bits.
//   x    [DIGIT] : minuend digit
//   y    [DIGIT] : subtrahend digit
//   bin          : borrow into bit 0 of the digit
//   d    [DIGIT] : difference digit
//   bout         : borrow out of the top bit of the digit
// ----------------------------------------------------------------------------
module digit_sub #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             bin,
    output logic [DIGIT-1:0] d,
    output logic             bout
);

    // chain[i] is the borrow entering bit i; chain[DIGIT] leaves the digit.
    logic [DIGIT:0] chain;

    assign chain[0] = bin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        full_sub u_full_sub (
            .x   (x[i]),
            .y   (y[i]),
            .bin (chain[i]),
            .d   (d[i]),
            .bout(chain[i+1])
        );
    end

    assign bout = chain[DIGIT];

endmodule

// File: rtl/serial_borrow_subtractor.sv
// ----------------------------------------------------------------------------
// serial_borrow_subtractor
//
// Digit-serial subtractor: diff = a - b - b_in over WIDTH bits, processing
// DIGIT bits per clock through one ripple-borrow slice and a borrow register.
// An operation takes STEPS = WIDTH/DIGIT compute cycles; the result is held
// under a valid/ready handshake until the consumer takes it.
//
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : a, b, b_in present
//   in_ready   : block can accept an operation (only in IDLE)
//   a [WIDTH]  : minuend
//   b [WIDTH]  : subtrahend
//   b_in       : borrow-in to bit 0
//   out_valid  : diff/borrow/ovf hold a complete result
//   out_ready  : consumer takes the result
//   diff[WIDTH]: a - b - b_in modulo 2^WIDTH
//   borrow     : borrow out of the MSB (unsigned a < b + b_in)
//   ovf        : two's complement overflow of a - b - b_in
// ----------------------------------------------------------------------------
module serial_borrow_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    localparam int STEPS = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
    localparam int CNT_W = cnt_width(STEPS);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    // Reject configurations the digit slicing cannot represent.
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
        $error("serial_borrow_subtractor: WIDTH must be >= 1 and a multiple of DIGIT");
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_e             state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [WIDTH-1:0]   a_q,         a_d;
    logic [WIDTH-1:0]   b_q,         b_d;
    logic               brw_q,       brw_d;
    logic [WIDTH-1:0]   diff_q,      diff_d;
    logic               borrow_q,    borrow_d;
    logic               ovf_q,       ovf_d;
    logic               in_ready_q,  in_ready_d;
    logic               out_valid_q, out_valid_d;

    // ------------------------------------------------------------------------
    // Digit slice
    // ------------------------------------------------------------------------
    logic [DIGIT-1:0]   x_dig;
    logic [DIGIT-1:0]   y_dig;
    logic [DIGIT-1:0]   d_dig;
    logic               bout_dig;

    // The slice always looks at the digit selected by the step counter.
    always_comb begin
        x_dig = a_q[int'(cnt_q) * DIGIT +: DIGIT];
        y_dig = b_q[int'(cnt_q) * DIGIT +: DIGIT];
    end

    digit_sub #(
        .DIGIT(DIGIT)
    ) u_digit_sub (
        .x   (x_dig),
        .y   (y_dig),
        .bin (brw_q),
        .d   (d_dig),
        .bout(bout_dig)
    );

    // ------------------------------------------------------------------------
    // Next-state logic: accept in IDLE, one digit per cycle in RUN, hold the
    // result in DONE until the consumer takes it. On the final step the top
    // bit of the current digit is the MSB of diff, which together with the
    // operand sign bits gives signed overflow.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        brw_d       = brw_q;
        diff_d      = diff_q;
        borrow_d    = borrow_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d        = a;
                    b_d        = b;
                    brw_d      = b_in;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = RUN;
                end
            end

            RUN: begin
                diff_d[int'(cnt_q) * DIGIT +: DIGIT] = d_dig;
                brw_d = bout_dig;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    cnt_d       = '0;
                    borrow_d    = bout_dig;
                    ovf_d       = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                  (d_dig[DIGIT-1] != a_q[WIDTH-1]);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end

            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                cnt_d       = '0;
                brw_d       = 1'b0;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and output registers. Reset discards any operation in flight so
    // a partial result can never be presented.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            brw_q       <= 1'b0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            brw_q       <= brw_d;
            diff_q      <= diff_d;
            borrow_q    <= borrow_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign borrow    = borrow_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// ----------------------------------------------------------------------------
// tb_serial_borrow_subtractor
//
// Drives five configurations of serial_borrow_subtractor (16/4, 16/1, 16/16,
// 8/2, 32/8) from one directed initial block and compares every result with
// a plain-arithmetic model of a - b - b_in.
// ----------------------------------------------------------------------------
module tb_serial_borrow_subtractor;

    localparam int NCFG = 5;
    localparam int W [NCFG] = '{16, 16, 16, 8, 32};
    localparam int S [NCFG] = '{4, 16, 1, 4, 4};

    logic clk;
    logic rst_n;

    logic        iv  [NCFG];
    logic        ir  [NCFG];
    logic [31:0] av  [NCFG];
    logic [31:0] bv  [NCFG];
    logic        bi  [NCFG];
    logic        ov  [NCFG];
    logic        orr [NCFG];
    logic        bo  [NCFG];
    logic        of  [NCFG];

    logic [15:0] d0;
    logic [15:0] d1;
    logic [15:0] d2;
    logic [7:0]  d3;
    logic [31:0] d4;

    int total;
    int bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    serial_borrow_subtractor #(.WIDTH(16), .DIGIT(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(av[0][15:0]), .b(bv[0][15:0]), .b_in(bi[0]), .out_valid(ov[0]),
        .out_ready(orr[0]), .diff(d0), .borrow(bo[0]), .ovf(of[0]));

    serial_borrow_subtractor #(.WIDTH(16), .DIGIT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(av[1][15:0]), .b(bv[1][15:0]), .b_in(bi[1]), .out_valid(ov[1]),
        .out_ready(orr[1]), .diff(d1), .borrow(bo[1]), .ovf(of[1]));

    serial_borrow_subtractor #(.WIDTH(16), .DIGIT(16)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(av[2][15:0]), .b(bv[2][15:0]), .b_in(bi[2]), .out_valid(ov[2]),
        .out_ready(orr[2]), .diff(d2), .borrow(bo[2]), .ovf(of[2]));

    serial_borrow_subtractor #(.WIDTH(8), .DIGIT(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]),
        .a(av[3][7:0]), .b(bv[3][7:0]), .b_in(bi[3]), .out_valid(ov[3]),
        .out_ready(orr[3]), .diff(d3), .borrow(bo[3]), .ovf(of[3]));

    serial_borrow_subtractor #(.WIDTH(32), .DIGIT(8)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[4]), .in_ready(ir[4]),
        .a(av[4]), .b(bv[4]), .b_in(bi[4]), .out_valid(ov[4]),
        .out_ready(orr[4]), .diff(d4), .borrow(bo[4]), .ovf(of[4]));

    // Zero-extended diff of the selected configuration.
    function automatic logic [31:0] get_diff(input int idx);
        case (idx)
            0:       return {16'd0, d0};
            1:       return {16'd0, d1};
            2:       return {16'd0, d2};
            3:       return {24'd0, d3};
            default: return d4;
        endcase
    endfunction

    // Reference: interpret operands as w-bit unsigned and signed integers and
    // subtract with 64-bit arithmetic, then read off wrap, borrow and range.
    function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input logic bin, output logic [31:0] d,
                                  output logic brw, output logic ovfl);
        longint one, mask, ua, ub, sa, sb, r, lo, hi, lb;
        one  = 1;
        mask = (one << w) - one;
        lb   = bin ? one : 0;
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        brw  = (ua < ub + lb);
        d    = 32'((ua - ub - lb) & mask);
        sa   = (ua >= (one << (w - 1))) ? ua - (one << w) : ua;
        sb   = (ub >= (one << (w - 1))) ? ub - (one << w) : ub;
        r    = sa - sb - lb;
        lo   = -(one << (w - 1));
        hi   = (one << (w - 1)) - one;
        ovfl = (r < lo) || (r > hi);
    endfunction

    task automatic checkOutput(input string tag, input int idx,
                               input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s cfg=%0d observed=0x%0h expected=0x%0h", tag, idx, obs, exp);
        end
    endtask

    // Random operand with a bias toward corner values.
    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 4))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000 >> $urandom_range(0, 24);
            3:       return 32'h7FFF_FFFF >> $urandom_range(0, 24);
            default: return $urandom;
        endcase
    endfunction

    // One complete operation: accept, measure latency, check the result,
    // hold it under backpressure for 'hold' cycles while offering junk
    // inputs, then take it and check the return to IDLE.
    task automatic applyStimulus(input int idx, input logic [31:0] a, input logic [31:0] b,
                                 input logic bin, input int hold);
        logic [31:0] ed;
        logic        eb;
        logic        eo;
        int          t;
        model(W[idx], a, b, bin, ed, eb, eo);

        t = 0;
        while (ir[idx] !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        checkOutput("in_ready_idle", idx, 32'(ir[idx]), 32'd1);

        av[idx] = a;
        bv[idx] = b;
        bi[idx] = bin;
        iv[idx] = 1'b1;
        @(posedge clk);
        @(negedge clk);

        t = 0;
        while (ov[idx] !== 1'b1 && t < 200) begin
            iv[idx]  = 1'($urandom_range(0, 1));
            av[idx]  = $urandom;
            bv[idx]  = $urandom;
            bi[idx]  = 1'($urandom_range(0, 1));
            orr[idx] = 1'($urandom_range(0, 1));
            @(negedge clk);
            t++;
        end
        orr[idx] = 1'b0;
        checkOutput("latency", idx, 32'(t), 32'(S[idx]));
        checkOutput("diff", idx, get_diff(idx), ed);
        checkOutput("borrow", idx, 32'(bo[idx]), 32'(eb));
        checkOutput("ovf", idx, 32'(of[idx]), 32'(eo));

        for (int k = 0; k < hold; k++) begin
            iv[idx] = ~iv[idx];
            av[idx] = $urandom;
            bv[idx] = $urandom;
            bi[idx] = 1'($urandom_range(0, 1));
            @(negedge clk);
            checkOutput("hold_valid", idx, 32'(ov[idx]), 32'd1);
            checkOutput("hold_in_ready", idx, 32'(ir[idx]), 32'd0);
            checkOutput("hold_diff", idx, get_diff(idx), ed);
            checkOutput("hold_borrow", idx, 32'(bo[idx]), 32'(eb));
            checkOutput("hold_ovf", idx, 32'(of[idx]), 32'(eo));
        end

        orr[idx] = 1'b1;
        @(negedge clk);
        orr[idx] = 1'b0;
        iv[idx]  = 1'b0;
        checkOutput("taken_valid", idx, 32'(ov[idx]), 32'd0);
        checkOutput("taken_in_ready", idx, 32'(ir[idx]), 32'd1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        for (int i = 0; i < NCFG; i++) begin
            iv[i]  = 1'b0;
            av[i]  = '0;
            bv[i]  = '0;
            bi[i]  = 1'b0;
            orr[i] = 1'b0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready", 0, 32'(ir[0]), 32'd1);
        checkOutput("rst_out_valid", 0, 32'(ov[0]), 32'd0);
        checkOutput("rst_diff", 0, get_diff(0), 32'd0);
        checkOutput("rst_borrow", 0, 32'(bo[0]), 32'd0);
        checkOutput("rst_ovf", 0, 32'(of[0]), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors on the 16/4 build
        applyStimulus(0, 32'h1234, 32'h0234, 1'b0, 1);
        checkOutput("basic_const", 0, get_diff(0), 32'h1000);
        applyStimulus(0, 32'h0000, 32'h0001, 1'b0, 1);
        applyStimulus(0, 32'h0005, 32'h0005, 1'b1, 1);
        applyStimulus(0, 32'h8000, 32'h0000, 1'b1, 1);
        applyStimulus(0, 32'h7FFF, 32'hFFFF, 1'b0, 1);

        // Backpressure: ten held cycles with junk inputs, then a fresh op
        applyStimulus(0, 32'hBEEF, 32'h1357, 1'b1, 10);
        applyStimulus(0, 32'h4000, 32'hC000, 1'b0, 0);

        // Reset two cycles into RUN
        av[0] = 32'hABCD;
        bv[0] = 32'h1111;
        bi[0] = 1'b0;
        iv[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 0, 32'(ov[0]), 32'd0);
        checkOutput("midrst_diff", 0, get_diff(0), 32'd0);
        checkOutput("midrst_borrow", 0, 32'(bo[0]), 32'd0);
        checkOutput("midrst_ovf", 0, 32'(of[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("postrst_in_ready", 0, 32'(ir[0]), 32'd1);
        checkOutput("postrst_out_valid", 0, 32'(ov[0]), 32'd0);
        applyStimulus(0, 32'hABCD, 32'h1111, 1'b0, 0);

        // Randomized sweep over every configuration
        for (int c = 0; c < NCFG; c++) begin
            for (int n = 0; n < 500; n++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                applyStimulus(c, pick_operand(), pick_operand(),
                              1'($urandom_range(0, 1)), $urandom_range(0, 3));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
